// File: rtl/spi_bram_burst_controller.sv
// Command-framed burst port between SPI RX/TX byte FIFOs and a synchronous-read BRAM.
// Frames are opcode, address (MSB first), length, then little-endian packed data words.
module spi_bram_burst_controller #(
    parameter int DATA_WIDTH     = 8,
    parameter int MEM_DEPTH      = 256,
    parameter int ADDR_WIDTH     = $clog2(MEM_DEPTH),
    parameter int BYTES_PER_WORD = DATA_WIDTH / 8,
    parameter int ADDR_BYTES     = (ADDR_WIDTH + 7) / 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic       frame_abort,
    output logic       busy,
    output logic       cmd_err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ADDR   = 3'd1;
    localparam logic [2:0] LEN    = 3'd2;
    localparam logic [2:0] WDATA  = 3'd3;
    localparam logic [2:0] RFETCH = 3'd4;
    localparam logic [2:0] RSEND  = 3'd5;

    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;

    localparam int BIDX_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int ABYTE_W = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
    localparam logic [BIDX_W-1:0]  LAST_BYTE  = BIDX_W'(BYTES_PER_WORD - 1);
    localparam logic [ABYTE_W-1:0] LAST_ABYTE = ABYTE_W'(ADDR_BYTES - 1);

    logic [2:0]            state;
    logic                  is_write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            count;
    logic [BIDX_W-1:0]     byte_idx;
    logic [ABYTE_W-1:0]    abyte_idx;
    logic [DATA_WIDTH-1:0] wbuf;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH+7:0] addr_shifted;
    logic                  rx_fire;
    logic                  mem_we;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    assign rx_fire      = rx_valid & rx_ready;
    assign addr_shifted = {addr, rx_data};
    assign busy         = (state != IDLE);
    assign tx_data      = shreg[7:0];
    assign mem_we       = (state == WDATA) && rx_fire && !frame_abort && (byte_idx == LAST_BYTE);

    // NOTE: give every combinational output a full default first so no latch is inferred.
    always_comb begin
        wr_word = wbuf;
        wr_word[byte_idx*8 +: 8] = rx_data;
    end

    // NOTE: the array has no reset so it maps onto block RAM; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr] <= wr_word;
        end
        if (state == RFETCH) begin
            rd_data <= mem[addr];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            is_write  <= 1'b0;
            addr      <= '0;
            count     <= '0;
            byte_idx  <= '0;
            abyte_idx <= '0;
            wbuf      <= '0;
            shreg     <= '0;
            rx_ready  <= 1'b0;
            tx_valid  <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            rx_ready <= 1'b1;
            cmd_err  <= 1'b0;
            if (frame_abort) begin
                // Abort wins over any byte in the same cycle; a half-built word is dropped.
                state    <= IDLE;
                tx_valid <= 1'b0;
                byte_idx <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rx_fire) begin
                            if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                                is_write  <= (rx_data == OP_WRITE);
                                abyte_idx <= '0;
                                state     <= ADDR;
                            end else begin
                                cmd_err <= 1'b1;
                            end
                        end
                    end
                    ADDR: begin
                        if (rx_fire) begin
                            addr <= addr_shifted[ADDR_WIDTH-1:0];
                            if (abyte_idx == LAST_ABYTE) begin
                                state <= LEN;
                            end else begin
                                abyte_idx <= abyte_idx + 1'b1;
                            end
                        end
                    end
                    LEN: begin
                        if (rx_fire) begin
                            count    <= rx_data;
                            byte_idx <= '0;
                            state    <= is_write ? WDATA : RFETCH;
                        end
                    end
                    WDATA: begin
                        if (rx_fire) begin
                            wbuf <= wr_word;
                            if (byte_idx == LAST_BYTE) begin
                                byte_idx <= '0;
                                addr     <= addr + 1'b1;
                                if (count == 8'd0) begin
                                    state <= IDLE;
                                end else begin
                                    count <= count - 1'b1;
                                end
                            end else begin
                                byte_idx <= byte_idx + 1'b1;
                            end
                        end
                    end
                    RFETCH: begin
                        state <= RSEND;
                    end
                    RSEND: begin
                        if (!tx_valid) begin
                            shreg    <= rd_data;
                            tx_valid <= 1'b1;
                            byte_idx <= '0;
                        end else if (tx_ready) begin
                            if (byte_idx == LAST_BYTE) begin
                                tx_valid <= 1'b0;
                                addr     <= addr + 1'b1;
                                if (count == 8'd0) begin
                                    state <= IDLE;
                                end else begin
                                    count <= count - 1'b1;
                                    state <= RFETCH;
                                end
                            end else begin
                                shreg    <= shreg >> 8;
                                byte_idx <= byte_idx + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_bram_burst_controller.sv
// Directed bench for spi_bram_burst_controller: three instances (8/16/32-bit words)
// share one byte driver, selected by sel; a vector table plus hand-written corner cases.
module tb_spi_bram_burst_controller;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_ready;
    logic       frame_abort;
    logic [1:0] sel;

    logic [2:0] rxv_i, txr_i, abt_i;
    logic [2:0] rxr_o, txv_o, busy_o, err_o;
    logic [7:0] txd_o [3];

    logic       rx_ready_m, tx_valid_m, busy_m;
    logic [7:0] tx_data_m;

    int n_cmp;
    int n_fail;
    int err_cnt;

    typedef struct packed {
        logic [1:0]  dut;
        int          n_cmd;
        logic [95:0] cmd;
        int          n_exp;
        logic [63:0] exp_b;
    } vec_t;

    assign rxv_i[0] = rx_valid && (sel == 2'd0);
    assign rxv_i[1] = rx_valid && (sel == 2'd1);
    assign rxv_i[2] = rx_valid && (sel == 2'd2);
    assign txr_i[0] = tx_ready && (sel == 2'd0);
    assign txr_i[1] = tx_ready && (sel == 2'd1);
    assign txr_i[2] = tx_ready && (sel == 2'd2);
    assign abt_i[0] = frame_abort && (sel == 2'd0);
    assign abt_i[1] = frame_abort && (sel == 2'd1);
    assign abt_i[2] = frame_abort && (sel == 2'd2);

    spi_bram_burst_controller #(.DATA_WIDTH(8), .MEM_DEPTH(256)) u_dw8 (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rxv_i[0]), .rx_ready(rxr_o[0]),
        .tx_data(txd_o[0]), .tx_valid(txv_o[0]), .tx_ready(txr_i[0]),
        .frame_abort(abt_i[0]), .busy(busy_o[0]), .cmd_err(err_o[0])
    );

    spi_bram_burst_controller #(.DATA_WIDTH(32), .MEM_DEPTH(256)) u_dw32 (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rxv_i[1]), .rx_ready(rxr_o[1]),
        .tx_data(txd_o[1]), .tx_valid(txv_o[1]), .tx_ready(txr_i[1]),
        .frame_abort(abt_i[1]), .busy(busy_o[1]), .cmd_err(err_o[1])
    );

    spi_bram_burst_controller #(.DATA_WIDTH(16), .MEM_DEPTH(256)) u_dw16 (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rxv_i[2]), .rx_ready(rxr_o[2]),
        .tx_data(txd_o[2]), .tx_valid(txv_o[2]), .tx_ready(txr_i[2]),
        .frame_abort(abt_i[2]), .busy(busy_o[2]), .cmd_err(err_o[2])
    );

    always_comb begin
        rx_ready_m = rxr_o[sel];
        tx_valid_m = txv_o[sel];
        tx_data_m  = txd_o[sel];
        busy_m     = busy_o[sel];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cmd_err is a one-cycle pulse, so one sample per cycle counts it exactly once.
    always @(negedge clk) begin
        if (|err_o) err_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
    endtask

    task automatic release_rx();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Collect n bytes with tx_ready high while the master clocks out 0xFF dummies.
    task automatic read_expect(input int n, input logic [63:0] exp_b, input string tag);
        int cyc = 0;
        int got = 0;
        tx_ready = 1'b1;
        while (got < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            rx_data  = 8'hFF;
            rx_valid = 1'b1;
            if (tx_valid_m) begin
                if (got == 0) check($sformatf("%s latency", tag), cyc - 1, 2);
                check($sformatf("%s byte%0d", tag, got), tx_data_m, exp_b[63-8*got -: 8]);
                got++;
                if (got == n) rx_valid = 1'b0;
            end
        end
        rx_valid = 1'b0;
        if (got < n) check($sformatf("%s timeout", tag), got, n);
        @(negedge clk);
        check($sformatf("%s busy after", tag), busy_m, 1'b0);
        check($sformatf("%s tx_valid after", tag), tx_valid_m, 1'b0);
    endtask

    function automatic vec_t mk(input logic [1:0] dut, input int n_cmd, input logic [95:0] c,
                                input int n_exp, input logic [63:0] e);
        vec_t v;
        v.dut   = dut;
        v.n_cmd = n_cmd;
        v.cmd   = c << (8 * (12 - n_cmd));
        v.n_exp = n_exp;
        v.exp_b = (n_exp == 0) ? 64'h0 : (e << (8 * (8 - n_exp)));
        return v;
    endfunction

    initial begin
        vec_t vecs [14];
        int   e0;
        int   cyc;
        int   got;
        logic pend;
        logic [7:0] held;
        logic [31:0] bp_exp;

        vecs[0]  = mk(0, 7,  96'h02_10_03_AA_BB_CC_DD, 0, 64'h0);
        vecs[1]  = mk(0, 3,  96'h03_10_03, 4, 64'hAA_BB_CC_DD);
        vecs[2]  = mk(1, 7,  96'h02_05_00_44_33_22_11, 0, 64'h0);
        vecs[3]  = mk(1, 3,  96'h03_05_00, 4, 64'h44_33_22_11);
        vecs[4]  = mk(0, 5,  96'h02_FF_01_11_22, 0, 64'h0);
        vecs[5]  = mk(0, 3,  96'h03_FF_01, 2, 64'h11_22);
        vecs[6]  = mk(0, 3,  96'h03_00_00, 1, 64'h22);
        vecs[7]  = mk(2, 5,  96'h02_20_00_EF_BE, 0, 64'h0);
        vecs[8]  = mk(1, 11, 96'h02_08_01_01_02_03_04_05_06_07_08, 0, 64'h0);
        vecs[9]  = mk(1, 3,  96'h03_08_01, 8, 64'h01_02_03_04_05_06_07_08);
        vecs[10] = mk(0, 5,  96'h02_40_01_FF_FE, 0, 64'h0);
        vecs[11] = mk(0, 3,  96'h03_40_01, 2, 64'hFF_FE);
        vecs[12] = mk(0, 3,  96'h03_11_01, 2, 64'hBB_CC);
        vecs[13] = mk(2, 3,  96'h03_20_00, 2, 64'hEF_BE);

        n_cmp = 0; n_fail = 0; err_cnt = 0;
        sel = 2'd0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1; frame_abort = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #20;
        check("reset rx_ready", rx_ready_m, 1'b0);
        check("reset tx_valid", tx_valid_m, 1'b0);
        check("reset tx_data", tx_data_m, 8'h00);
        check("reset busy all", busy_o, 3'b000);
        check("reset cmd_err all", err_o, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rx_ready after release", rx_ready_m, 1'b1);

        for (int i = 0; i < 14; i++) begin
            sel = vecs[i].dut;
            for (int b = 0; b < vecs[i].n_cmd; b++) send_byte(vecs[i].cmd[95-8*b -: 8]);
            if (vecs[i].n_exp > 0) begin
                read_expect(vecs[i].n_exp, vecs[i].exp_b, $sformatf("vec%0d", i));
            end else begin
                release_rx();
                check($sformatf("vec%0d busy after write", i), busy_m, 1'b0);
            end
        end
        @(negedge clk);
        check("no cmd_err during table", err_cnt, 0);

        // Back-pressure: 4-word read with random tx_ready, data must hold while stalled.
        sel = 2'd0;
        bp_exp = 32'hAA_BB_CC_DD;
        send_byte(8'h03); send_byte(8'h10); send_byte(8'h03);
        cyc = 0; got = 0; pend = 1'b0; held = 8'h00;
        while (got < 4 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            rx_valid = 1'b0;
            if (pend) begin
                check("bp stall valid held", tx_valid_m, 1'b1);
                check("bp stall data held", tx_data_m, held);
            end
            tx_ready = ($urandom_range(0, 1) == 1);
            if (tx_valid_m) begin
                if (tx_ready) begin
                    check($sformatf("bp byte%0d", got), tx_data_m, bp_exp[31-8*got -: 8]);
                    got++;
                    pend = 1'b0;
                end else begin
                    pend = 1'b1;
                    held = tx_data_m;
                end
            end
        end
        if (got < 4) check("bp timeout", got, 4);
        @(negedge clk);
        tx_ready = 1'b1;
        check("bp busy after", busy_m, 1'b0);

        // Abort a 16-bit write after one data byte; the abort-cycle byte must be ignored too.
        sel = 2'd2;
        e0 = err_cnt;
        send_byte(8'h02); send_byte(8'h20); send_byte(8'h00); send_byte(8'h55);
        @(negedge clk);
        rx_data = 8'h66; rx_valid = 1'b1; frame_abort = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; frame_abort = 1'b0;
        check("abort write busy", busy_m, 1'b0);
        @(negedge clk);
        check("abort write no cmd_err", err_cnt - e0, 0);
        send_byte(8'h03); send_byte(8'h20); send_byte(8'h00);
        read_expect(2, 64'hEF_BE_00_00_00_00_00_00, "abort write readback");

        // Abort during a stalled read: tx_valid must drop the next cycle.
        sel = 2'd0;
        send_byte(8'h03); send_byte(8'h10); send_byte(8'h03);
        cyc = 0;
        @(negedge clk);
        rx_valid = 1'b0; tx_ready = 1'b0;
        while (!tx_valid_m && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("abort read tx_valid seen", tx_valid_m, 1'b1);
        frame_abort = 1'b1;
        @(negedge clk);
        frame_abort = 1'b0; tx_ready = 1'b1;
        check("abort read tx_valid drop", tx_valid_m, 1'b0);
        check("abort read busy", busy_m, 1'b0);
        @(negedge clk);
        check("abort read stays idle", tx_valid_m, 1'b0);

        // Unknown opcode in IDLE: exactly one cmd_err pulse, no state change.
        e0 = err_cnt;
        send_byte(8'h7E);
        release_rx();
        @(negedge clk);
        check("cmd_err pulse count", err_cnt - e0, 1);
        check("cmd_err busy", busy_m, 1'b0);

        // Asynchronous reset in the middle of a read burst.
        send_byte(8'h03); send_byte(8'h10); send_byte(8'h03);
        cyc = 0;
        @(negedge clk);
        rx_valid = 1'b0;
        while (!tx_valid_m && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("reset-mid first byte", tx_data_m, 8'hAA);
        #2 rst_n = 1'b0;
        #1;
        check("reset-mid tx_valid", tx_valid_m, 1'b0);
        check("reset-mid busy", busy_m, 1'b0);
        check("reset-mid rx_ready", rx_ready_m, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset-mid rx_ready back", rx_ready_m, 1'b1);
        send_byte(8'h03); send_byte(8'h10); send_byte(8'h03);
        read_expect(4, 64'hAA_BB_CC_DD_00_00_00_00, "post-reset read");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
